// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch/jump squash and forwarding selects for the ID/EX feedback path,
// with saturating stall/flush event counters. State advances on the falling edge alongside the pipeline registers.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              Resetn,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_Rd,
    input  logic              ex_RegWr,
    input  logic              ex_MemtoReg,
    input  logic              ex_Branch,
    input  logic              ex_Jump,
    input  logic              ex_taken,
    input  logic [REG_AW-1:0] mem_Rd,
    input  logic              mem_RegWr,
    input  logic [REG_AW-1:0] wb_Rd,
    input  logic              wb_RegWr,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              redirect,
    output logic [1:0]        fwdA_sel,
    output logic [1:0]        fwdB_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam logic S_RUN   = 1'b0;
    localparam logic S_FLUSH = 1'b1;

    logic             r_state;
    logic [2:0]       r_fl_left;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_redir_ev, w_lu_ev, w_take_redir, w_take_stall, w_in_flush;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_redir_ev = ex_Jump | (ex_Branch & ex_taken);
    assign w_lu_ev    = ex_MemtoReg & ex_RegWr & (ex_Rd != '0) &
                        ((id_rs1_used & (id_rs1 == ex_Rd)) | (id_rs2_used & (id_rs2 == ex_Rd)));

    // Redirect outranks load-use; neither is acted on while squashing.
    assign w_take_redir = Resetn & (r_state == S_RUN) & w_redir_ev;
    assign w_take_stall = Resetn & (r_state == S_RUN) & w_lu_ev & ~w_redir_ev;
    assign w_in_flush   = Resetn & (r_state == S_FLUSH);

    assign w_fwd_a = (mem_RegWr & (mem_Rd != '0) & (mem_Rd == ex_rs1)) ? 2'b01 :
                     (wb_RegWr  & (wb_Rd  != '0) & (wb_Rd  == ex_rs1)) ? 2'b10 : 2'b00;
    assign w_fwd_b = (mem_RegWr & (mem_Rd != '0) & (mem_Rd == ex_rs2)) ? 2'b01 :
                     (wb_RegWr  & (wb_Rd  != '0) & (wb_Rd  == ex_rs2)) ? 2'b10 : 2'b00;

    assign redirect    = w_take_redir;
    assign ifid_flush  = w_take_redir | w_in_flush;
    assign idex_bubble = w_take_redir | w_take_stall | w_in_flush;
    assign pc_hold     = w_take_stall;
    assign ifid_hold   = w_take_stall;
    assign fwdA_sel    = Resetn ? w_fwd_a : 2'b00;
    assign fwdB_sel    = Resetn ? w_fwd_b : 2'b00;
    assign stall_cnt   = Resetn ? r_stall_cnt : '0;
    assign flush_cnt   = Resetn ? r_flush_cnt : '0;

    always_ff @(negedge CLK) begin
        if (!Resetn) begin
            r_state     <= S_RUN;
            r_fl_left   <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_take_redir) begin
            if (FLUSH_CYCLES > 1) begin
                r_state   <= S_FLUSH;
                r_fl_left <= 3'(FLUSH_CYCLES - 1);
            end
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end else if (w_take_stall) begin
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else if (w_in_flush) begin
            r_fl_left <= r_fl_left - 3'd1;
            if (r_fl_left == 3'd1) r_state <= S_RUN;
        end
    end
endmodule
